// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared definitions for the single-clock programmable FIFO.
//   ptr_width()    : width of the read/write pointers and the level count
//                    (ASIZE+1). The extra MSB keeps full and empty apart.
//                    Modules declare pointers as logic [ptr_width(ASIZE)-1:0];
//                    no separate pointer typedef is needed.
//   fifo_status_t  : bundle of the decoded status flags.
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  function automatic int ptr_width(input int asize);
    return asize + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic afull;
    logic empty;
    logic aempty;
  } fifo_status_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
// Simple dual-port RAM, DSIZE x 2**ASIZE, one write port and one registered
// read port. Only the read output register is reset (to 0); the array itself
// is never cleared.
// Ports:
//   clk      : clock
//   rst      : asynchronous active-high reset of the read register
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   re_i     : read enable; rdata_o holds its value when low
//   raddr_i  : read address
//   rdata_o  : registered read data
// -----------------------------------------------------------------------------
module sync_fifo_mem #(
  parameter int DSIZE = 16,
  parameter int ASIZE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [ASIZE-1:0] waddr_i,
  input  logic [DSIZE-1:0] wdata_i,
  input  logic             re_i,
  input  logic [ASIZE-1:0] raddr_i,
  output logic [DSIZE-1:0] rdata_o
);

  logic [DSIZE-1:0] mem [2**ASIZE];
  logic [DSIZE-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_prog.sv
// -----------------------------------------------------------------------------
// sync_fifo_prog
// Single-clock FIFO with run-time almost-full/almost-empty thresholds, a fill
// level output, synchronous flush and sticky overflow/underflow flags.
// Compile-time option: define SYNC_FIFO_FWFT_EN for first-word-fall-through
// (the RAM read register doubles as the head-of-queue register).
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   flush             : synchronous clear of contents and error flags
//   winc, wdata       : write request and data
//   wfull, awfull     : full, level >= afull_thresh
//   afull_thresh      : almost-full threshold (ASIZE+1 bits)
//   rinc, rdata       : read request and data
//   rempty, arempty   : empty, level <= aempty_thresh
//   aempty_thresh     : almost-empty threshold (ASIZE+1 bits)
//   level             : words held, 0..2**ASIZE
//   overflow          : sticky, write attempted while full
//   underflow         : sticky, read attempted while empty
// -----------------------------------------------------------------------------
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int DSIZE = 16,
  parameter int ASIZE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             awfull,
  input  logic [ASIZE:0]   afull_thresh,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             arempty,
  input  logic [ASIZE:0]   aempty_thresh,
  output logic [ASIZE:0]   level,
  output logic             overflow,
  output logic             underflow
);

  localparam int LW = ptr_width(ASIZE);
  localparam logic [LW-1:0] FULL_LVL = {1'b1, {ASIZE{1'b0}}};

  logic [LW-1:0] wptr_q, wptr_d;
  logic [LW-1:0] rptr_q, rptr_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic [LW-1:0] mem_cnt;   // words still in the RAM
  logic [LW-1:0] level_w;   // words visible to the user
  logic          empty_w;
  logic          wr_acc;
  logic          ram_re;    // RAM read; advances rptr
  fifo_status_t  st;

  assign mem_cnt = wptr_q - rptr_q;

`ifdef SYNC_FIFO_FWFT_EN
  logic out_valid_q, out_valid_d;
  logic pop;

  assign level_w = mem_cnt + {{ASIZE{1'b0}}, out_valid_q};
  assign empty_w = !out_valid_q;
  assign pop     = rinc && out_valid_q;
  // Refill the head whenever it is empty or being popped this cycle, so the
  // next word is presented after the same edge as the pop.
  assign ram_re  = !flush && (mem_cnt != '0) && (!out_valid_q || pop);

  always_comb begin
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (ram_re) begin
      out_valid_d = 1'b1;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
    end
  end
`else
  assign level_w = mem_cnt;
  assign empty_w = (mem_cnt == '0);
  assign ram_re  = rinc && !empty_w && !flush;
`endif

  assign st = '{
    full:   (level_w == FULL_LVL),
    afull:  (level_w >= afull_thresh),
    empty:  empty_w,
    aempty: (level_w <= aempty_thresh)
  };

  assign wr_acc = winc && !st.full && !flush;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + LW'(1);
      if (ram_re) rptr_d = rptr_q + LW'(1);
      if (winc && st.full)  ovf_d = 1'b1;
      if (rinc && st.empty) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  sync_fifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_acc),
    .waddr_i (wptr_q[ASIZE-1:0]),
    .wdata_i (wdata),
    .re_i    (ram_re),
    .raddr_i (rptr_q[ASIZE-1:0]),
    .rdata_o (rdata)
  );

  assign wfull     = st.full;
  assign awfull    = st.afull;
  assign rempty    = st.empty;
  assign arempty   = st.aempty;
  assign level     = level_w;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
module tb_sync_fifo_prog;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        winc;
  logic [15:0] wdata;
  logic        wfull;
  logic        awfull;
  logic [4:0]  afull_thresh;
  logic        rinc;
  logic [15:0] rdata;
  logic        rempty;
  logic        arempty;
  logic [4:0]  aempty_thresh;
  logic [4:0]  level;
  logic        overflow;
  logic        underflow;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] sb[$];
  int          exp_level;
  logic [15:0] exp;

  always #5 clk = ~clk;

  sync_fifo_prog #(.DSIZE(16), .ASIZE(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .winc          (winc),
    .wdata         (wdata),
    .wfull         (wfull),
    .awfull        (awfull),
    .afull_thresh  (afull_thresh),
    .rinc          (rinc),
    .rdata         (rdata),
    .rempty        (rempty),
    .arempty       (arempty),
    .aempty_thresh (aempty_thresh),
    .level         (level),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb.delete();
    exp_level = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 0; winc = 0; rinc = 0; wdata = '0;
    afull_thresh = 5'd12; aempty_thresh = 5'd1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    exp_level = 0;
    checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL reset_rempty got %b exp 1", rempty); end
    checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL reset_wfull got %b exp 0", wfull); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (arempty !== 1'b1) begin errors++; $display("FAIL reset_arempty got %b exp 1", arempty); end
    checks++; if (awfull !== 1'b0) begin errors++; $display("FAIL reset_awfull got %b exp 0", awfull); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {overflow, underflow}); end
    checks++; if (rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0000", rdata); end
    $display("reset done level=%0d rempty=%b", level, rempty);
  endtask

  task automatic test_fill_overflow();
    afull_thresh = 5'd16; aempty_thresh = 5'd1;
    for (int i = 0; i < 16; i++) begin
      winc = 1'b1; wdata = 16'(i);
      tick();
      sb.push_back(16'(i)); exp_level++;
      checks++; if (level !== 5'(exp_level)) begin errors++; $display("FAIL fill_level%0d got %0d exp %0d", i, level, exp_level); end
      checks++; if (wfull !== (exp_level == 16)) begin errors++; $display("FAIL fill_wfull%0d got %b exp %b", i, wfull, exp_level == 16); end
      $display("wr %h level=%0d", wdata, level);
    end
    wdata = 16'hDEAD;
    tick();
    winc = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d exp 16", level); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL ovf_unf got %b exp 0", underflow); end
    for (int i = 0; i < 16; i++) begin
      rinc = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
      exp = sb.pop_front();
      checks++; if (rdata !== exp) begin errors++; $display("FAIL fill_rd%0d got %h exp %h", i, rdata, exp); end
      tick();
`else
      tick();
      exp = sb.pop_front();
      checks++; if (rdata !== exp) begin errors++; $display("FAIL fill_rd%0d got %h exp %h", i, rdata, exp); end
`endif
      exp_level--;
      $display("rd %h exp %h level=%0d", rdata, exp, level);
    end
    rinc = 1'b0;
    checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL drain_rempty got %b exp 1", rempty); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL drain_level got %0d exp 0", level); end
`ifndef SYNC_FIFO_FWFT_EN
    tick();
    checks++; if (rdata !== 16'd15) begin errors++; $display("FAIL rdata_hold got %h exp 000f", rdata); end
`endif
    do_flush();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_ovf got %b exp 0", overflow); end
  endtask

  task automatic test_thresholds();
    afull_thresh = 5'd12; aempty_thresh = 5'd3;
    for (int i = 0; i < 12; i++) begin
      winc = 1'b1; wdata = 16'(16'h200 + i);
      tick();
      sb.push_back(wdata); exp_level++;
      checks++; if (awfull !== (exp_level >= 12)) begin errors++; $display("FAIL thr_awfull%0d got %b exp %b", i, awfull, exp_level >= 12); end
      checks++; if (arempty !== (exp_level <= 3)) begin errors++; $display("FAIL thr_arempty_w%0d got %b exp %b", i, arempty, exp_level <= 3); end
      $display("wr %h level=%0d awfull=%b", wdata, level, awfull);
    end
    winc = 1'b0;
    for (int i = 0; i < 9; i++) begin
      rinc = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
      exp = sb.pop_front();
      checks++; if (rdata !== exp) begin errors++; $display("FAIL thr_rd%0d got %h exp %h", i, rdata, exp); end
      tick();
`else
      tick();
      exp = sb.pop_front();
      checks++; if (rdata !== exp) begin errors++; $display("FAIL thr_rd%0d got %h exp %h", i, rdata, exp); end
`endif
      exp_level--;
      checks++; if (arempty !== (exp_level <= 3)) begin errors++; $display("FAIL thr_arempty_r%0d got %b exp %b", i, arempty, exp_level <= 3); end
      $display("rd %h exp %h level=%0d arempty=%b", rdata, exp, level, arempty);
    end
    rinc = 1'b0;
    checks++; if (level !== 5'd3) begin errors++; $display("FAIL thr_level got %0d exp 3", level); end
    do_flush();
    afull_thresh = 5'd0;
    #1;
    checks++; if (awfull !== 1'b1) begin errors++; $display("FAIL thr_zero_awfull got %b exp 1", awfull); end
    afull_thresh = 5'd16; aempty_thresh = 5'd1;
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 15; i++) begin
        winc = 1'b1; wdata = 16'($urandom);
        tick();
        sb.push_back(wdata); exp_level++;
      end
      winc = 1'b0;
      checks++; if (level !== 5'(exp_level)) begin errors++; $display("FAIL wrap_fill%0d got %0d exp %0d", r, level, exp_level); end
      for (int i = 0; i < 15; i++) begin
        rinc = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
        exp = sb.pop_front();
        checks++; if (rdata !== exp) begin errors++; $display("FAIL wrap_rd%0d_%0d got %h exp %h", r, i, rdata, exp); end
        tick();
`else
        tick();
        exp = sb.pop_front();
        checks++; if (rdata !== exp) begin errors++; $display("FAIL wrap_rd%0d_%0d got %h exp %h", r, i, rdata, exp); end
`endif
        exp_level--;
        $display("rd round %0d got %h exp %h", r, rdata, exp);
      end
      rinc = 1'b0;
      checks++; if (level !== 5'd0) begin errors++; $display("FAIL wrap_level%0d got %0d exp 0", r, level); end
      checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL wrap_flags%0d got %b exp 00", r, {overflow, underflow}); end
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 16; i++) begin
      winc = 1'b1; wdata = 16'(16'h100 + i);
      tick();
      sb.push_back(wdata); exp_level++;
    end
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL sim_full_level got %0d exp 16", level); end
    aempty_thresh = 5'd16;
    #1;
    checks++; if (arempty !== 1'b1) begin errors++; $display("FAIL sim_max_arempty got %b exp 1", arempty); end
    aempty_thresh = 5'd1;
    winc = 1'b1; rinc = 1'b1; wdata = 16'hBEEF;
`ifdef SYNC_FIFO_FWFT_EN
    exp = sb.pop_front();
    checks++; if (rdata !== exp) begin errors++; $display("FAIL sim_full_rd got %h exp %h", rdata, exp); end
    tick();
`else
    tick();
    exp = sb.pop_front();
    checks++; if (rdata !== exp) begin errors++; $display("FAIL sim_full_rd got %h exp %h", rdata, exp); end
`endif
    winc = 1'b0; rinc = 1'b0;
    $display("full wr+rd rd %h level=%0d ovf=%b", rdata, level, overflow);
    checks++; if (level !== 5'd15) begin errors++; $display("FAIL sim_full_level15 got %0d exp 15", level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sim_full_ovf got %b exp 1", overflow); end
    do_flush();
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL sim_flush_level got %0d exp 0", level); end
    winc = 1'b1; rinc = 1'b1; wdata = 16'h0055;
    tick();
    winc = 1'b0; rinc = 1'b0;
    $display("empty wr+rd level=%0d unf=%b", level, underflow);
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL sim_empty_level got %0d exp 1", level); end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL sim_empty_unf got %b exp 1", underflow); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sim_empty_ovf got %b exp 0", overflow); end
    do_flush();
    checks++; if ({level, overflow, underflow} !== 7'd0) begin errors++; $display("FAIL sim_flush2 got %0d/%b/%b exp 0/0/0", level, overflow, underflow); end
    checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL sim_flush2_rempty got %b exp 1", rempty); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      winc = 1'b1; wdata = 16'(16'h300 + i);
      tick();
    end
    winc = 1'b0;
    checks++; if (level !== 5'd3) begin errors++; $display("FAIL arst_pre_level got %0d exp 3", level); end
    #2 rst = 1'b1;
    #1;
    checks++; if (level !== 5'd0 || rempty !== 1'b1) begin errors++; $display("FAIL arst_level got %0d/%b exp 0/1", level, rempty); end
    tick();
    rst = 1'b0;
    tick();
    sb.delete(); exp_level = 0;
    $display("async reset level=%0d", level);
  endtask

`ifdef SYNC_FIFO_FWFT_EN
  task automatic test_fwft();
    winc = 1'b1; wdata = 16'hA;
    tick();
    winc = 1'b0;
    checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL fwft_n got %b exp 1", rempty); end
    tick();
    checks++; if (rempty !== 1'b0) begin errors++; $display("FAIL fwft_n1 got %b exp 0", rempty); end
    checks++; if (rdata !== 16'hA) begin errors++; $display("FAIL fwft_rdata got %h exp 000a", rdata); end
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
    checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL fwft_pop got %b exp 1", rempty); end
    $display("fwft rd %h rempty=%b", rdata, rempty);
  endtask
`endif

  initial begin
    test_reset();
    test_fill_overflow();
    test_thresholds();
    test_wrap();
    test_simultaneous();
    test_async_reset();
`ifdef SYNC_FIFO_FWFT_EN
    test_fwft();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
